// File: rtl/cdc_event_arbiter.sv
// rtl/cdc_event_arbiter.sv - round-robin event arbiter feeding a toggle pulse synchronizer
//
// Latches single-cycle requests from N_REQ sources and forwards them one at a
// time across a clock-domain boundary: one sync_pulse per event, with evt_id
// held stable for the destination to sample.
//
// Ports:
//   clk_src      source clock, rising edge
//   rst_n_src    asynchronous active-low reset
//   en           allow new grants (an in-flight transfer always completes)
//   req          single-cycle event requests, one bit per requester
//   err_clr      clears timeout_err and drop_cnt
//   sync_pulse   pulse input of the toggle synchronizer
//   sync_ack     synchronizer idle / previous pulse seen by the destination
//   evt_id       index of the requester last sent (quasi-static)
//   pending      latched, not-yet-sent requests
//   busy         arbiter is not idle
//   drop_cnt     saturating count of cycles with coalesced requests
//   timeout_err  sticky ack-timeout flag
module cdc_event_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ID_W    = $clog2(N_REQ),
    parameter int TIMEOUT = 255
) (
    input  logic             clk_src,
    input  logic             rst_n_src,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    input  logic             err_clr,
    output logic             sync_pulse,
    input  logic             sync_ack,
    output logic [ID_W-1:0]  evt_id,
    output logic [N_REQ-1:0] pending,
    output logic             busy,
    output logic [7:0]       drop_cnt,
    output logic             timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_GUARD,
        S_WAIT_ACK,
        S_RECOVER
    } state_t;

    state_t           state_q, state_d;
    logic [ID_W-1:0]  evt_id_q, evt_id_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [N_REQ-1:0] pending_q, pending_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;
    logic             timeout_err_q, timeout_err_d;
    logic [15:0]      wait_cnt_q, wait_cnt_d;

    logic [ID_W-1:0]  grant_idx;
    logic             grant_vld;
    logic [N_REQ-1:0] clr_mask;
    logic             timeout_hit;
    logic             drop_any;

    // Round-robin search starting at rr_ptr_q; the candidate index is kept one
    // bit wider so the wrap can be done by a single subtraction.
    always_comb begin
        logic [ID_W:0] cand;
        cand      = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(N_REQ)) begin
                cand = cand - (ID_W+1)'(N_REQ);
            end
            if (!grant_vld && pending_q[cand[ID_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        evt_id_d    = evt_id_q;
        rr_ptr_d    = rr_ptr_q;
        wait_cnt_d  = wait_cnt_q;
        clr_mask    = '0;
        timeout_hit = 1'b0;
        case (state_q)
            S_IDLE: begin
                // sync_ack high guarantees the synchronizer can take a new pulse.
                if (en && grant_vld && sync_ack) begin
                    state_d  = S_SEND;
                    evt_id_d = grant_idx;
                    rr_ptr_d = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
                end
            end
            S_SEND: begin
                clr_mask   = N_REQ'(1) << evt_id_q;
                wait_cnt_d = '0;
                state_d    = S_GUARD;
            end
            S_GUARD: begin
                // The ack may still show the previous handshake this cycle.
                wait_cnt_d = wait_cnt_q + 16'd1;
                state_d    = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (sync_ack) begin
                    state_d = S_IDLE;
                end else if (wait_cnt_q >= 16'(TIMEOUT)) begin
                    timeout_hit = 1'b1;
                    state_d     = S_RECOVER;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            S_RECOVER: begin
                if (sync_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A new request for a source that is still pending is coalesced; a set
    // in the same cycle as the SEND clear keeps the bit.
    always_comb begin
        drop_any  = |(req & pending_q);
        pending_d = (pending_q & ~clr_mask) | req;

        drop_cnt_d = drop_cnt_q;
        if (drop_any) begin
            if (err_clr) begin
                drop_cnt_d = 8'd1;
            end else if (drop_cnt_q != 8'hff) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end else if (err_clr) begin
            drop_cnt_d = '0;
        end

        timeout_err_d = timeout_err_q;
        if (timeout_hit) begin
            timeout_err_d = 1'b1;
        end else if (err_clr) begin
            timeout_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk_src or negedge rst_n_src) begin
        if (!rst_n_src) begin
            state_q       <= S_IDLE;
            evt_id_q      <= '0;
            rr_ptr_q      <= '0;
            pending_q     <= '0;
            drop_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
            wait_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            evt_id_q      <= evt_id_d;
            rr_ptr_q      <= rr_ptr_d;
            pending_q     <= pending_d;
            drop_cnt_q    <= drop_cnt_d;
            timeout_err_q <= timeout_err_d;
            wait_cnt_q    <= wait_cnt_d;
        end
    end

    assign sync_pulse  = (state_q == S_SEND);
    assign busy        = (state_q != S_IDLE);
    assign evt_id      = evt_id_q;
    assign pending     = pending_q;
    assign drop_cnt    = drop_cnt_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_cdc_event_arbiter.sv
// tb/tb_cdc_event_arbiter.sv - scoreboard bench for cdc_event_arbiter
module tb_cdc_event_arbiter;

    localparam int N_REQ = 4;
    localparam int ID_W  = 2;

    logic             clk_src = 1'b0;
    logic             rst_n_src = 1'b0;
    logic             en = 1'b0;
    logic [N_REQ-1:0] req = '0;
    logic             err_clr = 1'b0;
    logic             sync_pulse;
    logic             sync_ack = 1'b1;
    logic [ID_W-1:0]  evt_id;
    logic [N_REQ-1:0] pending;
    logic             busy;
    logic [7:0]       drop_cnt;
    logic             timeout_err;

    int total = 0;
    int bad   = 0;

    int unsigned exp_q[$];
    int ack_delay = 6;
    int ack_cnt   = 0;
    bit ack_stall = 1'b0;

    cdc_event_arbiter #(.N_REQ(N_REQ), .TIMEOUT(10)) dut (
        .clk_src    (clk_src),
        .rst_n_src  (rst_n_src),
        .en         (en),
        .req        (req),
        .err_clr    (err_clr),
        .sync_pulse (sync_pulse),
        .sync_ack   (sync_ack),
        .evt_id     (evt_id),
        .pending    (pending),
        .busy       (busy),
        .drop_cnt   (drop_cnt),
        .timeout_err(timeout_err)
    );

    always #5 clk_src = ~clk_src;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Synchronizer model and scoreboard consumer: every pulse pops one
    // expected id; ack drops at the pulse and returns ack_delay cycles later.
    initial begin
        forever begin
            @(negedge clk_src);
            if (!rst_n_src) begin
                sync_ack = 1'b1;
                ack_cnt  = 0;
            end else if (sync_pulse) begin
                check("ack_hi_at_pulse", 32'(sync_ack), 32'd1);
                if (exp_q.size() == 0) begin
                    check("unexp_pulse", 32'(evt_id), 32'hdead);
                end else begin
                    check("evt_id", 32'(evt_id), exp_q.pop_front());
                end
                sync_ack = 1'b0;
                ack_cnt  = ack_delay;
            end else begin
                if (ack_cnt > 0) ack_cnt--;
                if (ack_cnt == 0 && !ack_stall) sync_ack = 1'b1;
            end
        end
    end

    task automatic do_reset();
        rst_n_src = 1'b0;
        en        = 1'b0;
        req       = '0;
        err_clr   = 1'b0;
        ack_stall = 1'b0;
        repeat (2) @(negedge clk_src);
        rst_n_src = 1'b1;
        @(negedge clk_src);
    endtask

    task automatic pulse_req(input logic [N_REQ-1:0] v);
        req = v;
        @(negedge clk_src);
        req = '0;
    endtask

    task automatic wait_pulse();
        bit seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk_src);
            if (sync_pulse) seen = 1'b1;
        end
        if (!seen) check("pulse_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done();
        bit done = 1'b0;
        for (int i = 0; i < 150 && !done; i++) begin
            @(negedge clk_src);
            if (exp_q.size() == 0 && !busy && pending == '0) done = 1'b1;
        end
        if (!done) check("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        do_reset();
        check("rst_busy",    32'(busy),        32'd0);
        check("rst_pulse",   32'(sync_pulse),  32'd0);
        check("rst_evt_id",  32'(evt_id),      32'd0);
        check("rst_pending", 32'(pending),     32'd0);
        check("rst_drop",    32'(drop_cnt),    32'd0);
        check("rst_tmo",     32'(timeout_err), 32'd0);

        // Single event, ack back after 6 cycles.
        en = 1'b1;
        exp_q.push_back(0);
        pulse_req(4'b0001);
        wait_pulse();
        @(negedge clk_src);
        check("t1_pending_clr", 32'(pending), 32'd0);
        repeat (5) @(negedge clk_src);
        check("t1_busy_wait", 32'(busy), 32'd1);
        @(negedge clk_src);
        check("t1_busy_idle", 32'(busy), 32'd0);

        // Three simultaneous requests drain in round-robin order from index 0.
        do_reset();
        en = 1'b1;
        exp_q.push_back(0);
        exp_q.push_back(1);
        exp_q.push_back(3);
        pulse_req(4'b1011);
        wait_done();
        check("t2_pending", 32'(pending), 32'd0);

        // Coalescing with en low, err_clr vs simultaneous drop, then enable.
        do_reset();
        pulse_req(4'b0100);
        repeat (2) @(negedge clk_src);
        for (int i = 0; i < 3; i++) begin
            pulse_req(4'b0100);
            @(negedge clk_src);
        end
        check("t3_drop3",   32'(drop_cnt), 32'd3);
        check("t3_pending", 32'(pending),  32'b0100);
        check("t3_idle",    32'(busy),     32'd0);
        req     = 4'b0100;
        err_clr = 1'b1;
        @(negedge clk_src);
        req     = '0;
        err_clr = 1'b0;
        check("t3_clr_drop_wins", 32'(drop_cnt), 32'd1);
        err_clr = 1'b1;
        @(negedge clk_src);
        err_clr = 1'b0;
        check("t3_clr", 32'(drop_cnt), 32'd0);
        exp_q.push_back(2);
        en = 1'b1;
        wait_pulse();
        wait_done();
        check("t3_drop_after", 32'(drop_cnt), 32'd0);

        // Ack timeout and recovery.
        do_reset();
        en        = 1'b1;
        ack_stall = 1'b1;
        exp_q.push_back(0);
        pulse_req(4'b0001);
        wait_pulse();
        repeat (8) @(negedge clk_src);
        check("t4_tmo_early", 32'(timeout_err), 32'd0);
        repeat (6) @(negedge clk_src);
        check("t4_tmo_set", 32'(timeout_err), 32'd1);
        check("t4_busy",    32'(busy),        32'd1);
        pulse_req(4'b0010);
        repeat (20) @(negedge clk_src);
        check("t4_held_pending", 32'(pending), 32'b0010);
        check("t4_still_busy",   32'(busy),    32'd1);
        exp_q.push_back(1);
        ack_stall = 1'b0;
        wait_pulse();
        wait_done();
        check("t4_tmo_sticky", 32'(timeout_err), 32'd1);
        err_clr = 1'b1;
        @(negedge clk_src);
        err_clr = 1'b0;
        check("t4_tmo_clr", 32'(timeout_err), 32'd0);

        // Drop counter saturation, then reset in the middle of WAIT_ACK.
        do_reset();
        req = 4'b0001;
        repeat (301) @(negedge clk_src);
        req = '0;
        check("t5_drop_sat", 32'(drop_cnt), 32'd255);
        ack_stall = 1'b1;
        exp_q.push_back(0);
        en = 1'b1;
        wait_pulse();
        pulse_req(4'b1000);
        repeat (2) @(negedge clk_src);
        check("t5_busy_pre", 32'(busy), 32'd1);
        #2 rst_n_src = 1'b0;
        ack_stall = 1'b0;
        #1;
        check("t5_rst_busy",    32'(busy),        32'd0);
        check("t5_rst_pulse",   32'(sync_pulse),  32'd0);
        check("t5_rst_evt_id",  32'(evt_id),      32'd0);
        check("t5_rst_pending", 32'(pending),     32'd0);
        check("t5_rst_drop",    32'(drop_cnt),    32'd0);
        check("t5_rst_tmo",     32'(timeout_err), 32'd0);
        repeat (2) @(negedge clk_src);
        rst_n_src = 1'b1;
        repeat (10) @(negedge clk_src);
        check("t5_no_pulse_after_rst", 32'(busy), 32'd0);

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
